// File: rtl/operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : operand_fetch
// Purpose  : Selects source operands from the register file (with same-cycle
//            writeback bypass), tracks outstanding writes to the three backed
//            registers with a scoreboard, and presents operands on a
//            registered valid/ready output stage.
// Revision : 1.0 - initial release
// ============================================================================
module operand_fetch #(
  parameter int ID_BASE = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  reg_id_a,
  input  logic [4:0]  reg_id_b,
  input  logic [4:0]  reg_id_d,
  input  logic [31:0] reg_0_value,
  input  logic [31:0] reg_1_value,
  input  logic [31:0] reg_2_value,
  input  logic        wb_enable,
  input  logic [4:0]  wb_reg_id,
  input  logic [31:0] wb_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  out_reg_id_d
);

  localparam logic [5:0] c_id_lo = 6'(ID_BASE);
  localparam logic [5:0] c_id_hi = 6'(ID_BASE + 2);

  // One-hot slot mask for an id; all-zero when the id is not backed.
  function automatic logic [2:0] f_slot_mask(input logic [4:0] id);
    logic [5:0] wide_id;
    logic [2:0] slot;
    wide_id = {1'b0, id};
    slot    = 3'(wide_id - c_id_lo);
    if ((wide_id >= c_id_lo) && (wide_id <= c_id_hi))
      f_slot_mask = 3'b001 << slot;
    else
      f_slot_mask = 3'b000;
  endfunction

  // Register file value for a one-hot slot mask; zero for unbacked ids.
  function automatic logic [31:0] f_select(input logic [2:0] mask,
                                           input logic [31:0] v0,
                                           input logic [31:0] v1,
                                           input logic [31:0] v2);
    f_select = ({32{mask[0]}} & v0) | ({32{mask[1]}} & v1) | ({32{mask[2]}} & v2);
  endfunction

  logic [2:0]  r_pending;
  logic        r_out_valid;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;
  logic [4:0]  r_reg_id_d;

  logic [2:0]  w_a_mask;
  logic [2:0]  w_b_mask;
  logic [2:0]  w_d_mask;
  logic [2:0]  w_wb_mask;
  logic [2:0]  w_live_pending;
  logic [2:0]  w_pending_nxt;
  logic        w_a_bypass;
  logic        w_b_bypass;
  logic [31:0] w_a_value;
  logic [31:0] w_b_value;
  logic        w_hazard;
  logic        w_space;
  logic        w_accept;

  // Operand selection, hazard detection and scoreboard next state.
  always_comb begin
    w_a_mask   = f_slot_mask(reg_id_a);
    w_b_mask   = f_slot_mask(reg_id_b);
    w_d_mask   = f_slot_mask(reg_id_d);
    w_wb_mask  = wb_enable ? f_slot_mask(wb_reg_id) : 3'b000;

    // The file is updated at the writeback edge, so during that cycle its
    // value is stale and the writeback data must be forwarded instead.
    w_a_bypass = wb_enable && (wb_reg_id == reg_id_a) && (|w_a_mask);
    w_b_bypass = wb_enable && (wb_reg_id == reg_id_b) && (|w_b_mask);
    w_a_value  = w_a_bypass ? wb_value
                            : f_select(w_a_mask, reg_0_value, reg_1_value, reg_2_value);
    w_b_value  = w_b_bypass ? wb_value
                            : f_select(w_b_mask, reg_0_value, reg_1_value, reg_2_value);

    // A slot being written back this cycle no longer blocks anyone.
    w_live_pending = r_pending & ~w_wb_mask;
    w_hazard       = |((w_a_mask | w_b_mask | w_d_mask) & w_live_pending);

    // in_ready deliberately excludes in_valid.
    w_space  = !r_out_valid || out_ready;
    in_ready = w_space && !w_hazard;
    w_accept = in_valid && in_ready;

    // Set after clear: a newly accepted writer owns the slot.
    w_pending_nxt = w_live_pending | (w_accept ? w_d_mask : 3'b000);
  end

  // Scoreboard and output stage registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending   <= 3'b000;
      r_out_valid <= 1'b0;
      r_op_a      <= 32'h0;
      r_op_b      <= 32'h0;
      r_reg_id_d  <= 5'h0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_accept) begin
        r_out_valid <= 1'b1;
        r_op_a      <= w_a_value;
        r_op_b      <= w_b_value;
        r_reg_id_d  <= reg_id_d;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign op_a         = r_op_a;
  assign op_b         = r_op_b;
  assign out_reg_id_d = r_reg_id_d;

endmodule
`default_nettype wire

// File: tb/tb_operand_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_fetch
// Purpose  : Directed vector table for the documented corner cases followed
//            by randomized traffic checked against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_fetch;

  localparam int BASE = 5;

  typedef struct {
    bit        rst;
    bit        iv;
    bit [4:0]  a;
    bit [4:0]  b;
    bit [4:0]  d;
    bit        wbe;
    bit [4:0]  wbid;
    bit [31:0] wbv;
    bit        ordy;
    bit        chk_ir;
    bit        eir;
    bit        eov;
    bit [31:0] ea;
    bit [31:0] eb;
    bit [4:0]  ed;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  reg_id_a;
  logic [4:0]  reg_id_b;
  logic [4:0]  reg_id_d;
  logic [31:0] reg_0_value;
  logic [31:0] reg_1_value;
  logic [31:0] reg_2_value;
  logic        wb_enable;
  logic [4:0]  wb_reg_id;
  logic [31:0] wb_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  out_reg_id_d;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: pending flags by architectural id, register file copy.
  bit          m_pend [32];
  bit          m_ov;
  logic [31:0] m_a;
  logic [31:0] m_b;
  logic [4:0]  m_d;
  logic [31:0] rf [3];

  vec_t tab [26];

  assign reg_0_value = rf[0];
  assign reg_1_value = rf[1];
  assign reg_2_value = rf[2];

  always #5 clk = ~clk;

  operand_fetch #(.ID_BASE(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .reg_id_a     (reg_id_a),
    .reg_id_b     (reg_id_b),
    .reg_id_d     (reg_id_d),
    .reg_0_value  (reg_0_value),
    .reg_1_value  (reg_1_value),
    .reg_2_value  (reg_2_value),
    .wb_enable    (wb_enable),
    .wb_reg_id    (wb_reg_id),
    .wb_value     (wb_value),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .op_a         (op_a),
    .op_b         (op_b),
    .out_reg_id_d (out_reg_id_d)
  );

  function automatic bit is_backed(input logic [4:0] id);
    return (int'(id) >= BASE) && (int'(id) <= BASE + 2);
  endfunction

  function automatic bit busy(input logic [4:0] id);
    return is_backed(id) && m_pend[id] && !(wb_enable && wb_reg_id == id);
  endfunction

  function automatic logic [31:0] src_val(input logic [4:0] id);
    if (!is_backed(id)) return 32'h0;
    if (wb_enable && wb_reg_id == id) return wb_value;
    return rf[int'(id) - BASE];
  endfunction

  function automatic bit model_ready();
    return (!m_ov || out_ready) && !busy(reg_id_a) && !busy(reg_id_b) && !busy(reg_id_d);
  endfunction

  // Advance the model by one clock edge using the inputs held across it.
  task automatic model_edge();
    bit acc;
    acc = in_valid && model_ready();
    if (reset) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_ov = 1'b0; m_a = 32'h0; m_b = 32'h0; m_d = 5'h0;
    end else begin
      if (wb_enable && is_backed(wb_reg_id)) m_pend[wb_reg_id] = 1'b0;
      if (acc) begin
        m_a = src_val(reg_id_a);
        m_b = src_val(reg_id_b);
        m_d = reg_id_d;
        m_ov = 1'b1;
        if (is_backed(reg_id_d)) m_pend[reg_id_d] = 1'b1;
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
    if (wb_enable && is_backed(wb_reg_id)) rf[int'(wb_reg_id) - BASE] = wb_value;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rst, input bit iv, input bit [4:0] a, input bit [4:0] b,
                              input bit [4:0] d, input bit wbe, input bit [4:0] wbid,
                              input bit [31:0] wbv, input bit ordy, input bit chk_ir,
                              input bit eir, input bit eov, input bit [31:0] ea,
                              input bit [31:0] eb, input bit [4:0] ed);
    vec_t v;
    v.rst = rst; v.iv = iv; v.a = a; v.b = b; v.d = d; v.wbe = wbe; v.wbid = wbid;
    v.wbv = wbv; v.ordy = ordy; v.chk_ir = chk_ir; v.eir = eir; v.eov = eov;
    v.ea = ea; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  // One clock cycle: drive, check in_ready mid-cycle, clock, check outputs.
  task automatic cycle(input vec_t v, input bit use_tab);
    reset = v.rst; in_valid = v.iv; reg_id_a = v.a; reg_id_b = v.b; reg_id_d = v.d;
    wb_enable = v.wbe; wb_reg_id = v.wbid; wb_value = v.wbv; out_ready = v.ordy;
    #1;
    if (use_tab) begin
      if (v.chk_ir) chk("in_ready", {31'b0, in_ready}, {31'b0, v.eir});
    end else begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
    end
    @(posedge clk);
    #1;
    model_edge();
    if (use_tab) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, v.eov});
      chk("op_a", op_a, v.ea);
      chk("op_b", op_b, v.eb);
      chk("out_reg_id_d", {27'b0, out_reg_id_d}, {27'b0, v.ed});
    end else begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
      chk("op_a", op_a, m_a);
      chk("op_b", op_b, m_b);
      chk("out_reg_id_d", {27'b0, out_reg_id_d}, {27'b0, m_d});
    end
  endtask

  initial begin
    bit [4:0] pool [6];
    vec_t rv;
    pool[0] = 5'd0; pool[1] = 5'd3; pool[2] = 5'd5;
    pool[3] = 5'd6; pool[4] = 5'd7; pool[5] = 5'd31;

    rf[0] = 32'hA0A0_0005; rf[1] = 32'h1111_2222; rf[2] = 32'hC0C0_0007;
    reset = 1'b1; in_valid = 1'b0; reg_id_a = '0; reg_id_b = '0; reg_id_d = '0;
    wb_enable = 1'b0; wb_reg_id = '0; wb_value = '0; out_ready = 1'b1;

    //            rst iv  a   b   d  wbe wbid wbv           ordy chk eir eov ea            eb            ed
    tab[0]  = mk(1, 1,  6,  0,  5, 0, 0, 32'h0,         1, 0, 0, 0, 32'h0,         32'h0,         0);
    tab[1]  = mk(0, 1,  6,  0,  0, 0, 0, 32'h0,         1, 1, 1, 1, 32'h1111_2222, 32'h0,         0);
    tab[2]  = mk(0, 1,  0,  0,  5, 0, 0, 32'h0,         1, 1, 1, 1, 32'h0,         32'h0,         5);
    tab[3]  = mk(0, 1,  5,  0,  0, 0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         5);
    tab[4]  = mk(0, 1,  5,  0,  0, 0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         5);
    tab[5]  = mk(0, 1,  5,  0,  0, 0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         5);
    tab[6]  = mk(0, 1,  5,  0,  0, 1, 5, 32'hDEAD_BEEF, 1, 1, 1, 1, 32'hDEAD_BEEF, 32'h0,         0);
    tab[7]  = mk(0, 1,  5,  7,  0, 0, 0, 32'h0,         0, 1, 0, 1, 32'hDEAD_BEEF, 32'h0,         0);
    tab[8]  = mk(0, 1,  5,  7,  0, 0, 0, 32'h0,         0, 1, 0, 1, 32'hDEAD_BEEF, 32'h0,         0);
    tab[9]  = mk(0, 1,  5,  7,  0, 0, 0, 32'h0,         0, 1, 0, 1, 32'hDEAD_BEEF, 32'h0,         0);
    tab[10] = mk(0, 1,  5,  7,  0, 0, 0, 32'h0,         0, 1, 0, 1, 32'hDEAD_BEEF, 32'h0,         0);
    tab[11] = mk(0, 1,  5,  7,  0, 0, 0, 32'h0,         1, 1, 1, 1, 32'hDEAD_BEEF, 32'hC0C0_0007, 0);
    tab[12] = mk(0, 1,  0,  0,  7, 0, 0, 32'h0,         1, 1, 1, 1, 32'h0,         32'h0,         7);
    tab[13] = mk(0, 1,  0,  0,  7, 1, 7, 32'h7777_0000, 1, 1, 1, 1, 32'h0,         32'h0,         7);
    tab[14] = mk(0, 1,  7,  0,  0, 0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         7);
    tab[15] = mk(0, 1,  7,  0,  0, 1, 7, 32'h1234_5678, 1, 1, 1, 1, 32'h1234_5678, 32'h0,         0);
    tab[16] = mk(0, 1,  0,  0,  6, 0, 0, 32'h0,         1, 1, 1, 1, 32'h0,         32'h0,         6);
    tab[17] = mk(0, 1,  0,  0,  6, 0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         6);
    tab[18] = mk(0, 1,  0,  0,  6, 1, 6, 32'h6666_6666, 1, 1, 1, 1, 32'h0,         32'h0,         6);
    tab[19] = mk(0, 1, 31,  0,  3, 0, 0, 32'h0,         1, 1, 1, 1, 32'h0,         32'h0,         3);
    tab[20] = mk(0, 1,  6,  0,  0, 0, 0, 32'h0,         1, 1, 0, 0, 32'h0,         32'h0,         3);
    tab[21] = mk(0, 1,  6,  0,  0, 1, 6, 32'hABCD_0001, 1, 1, 1, 1, 32'hABCD_0001, 32'h0,         0);
    tab[22] = mk(0, 1,  0,  0,  5, 0, 0, 32'h0,         1, 1, 1, 1, 32'h0,         32'h0,         5);
    tab[23] = mk(1, 1,  6,  0,  6, 0, 0, 32'h0,         0, 1, 0, 0, 32'h0,         32'h0,         0);
    tab[24] = mk(0, 1,  5,  5,  5, 0, 0, 32'h0,         1, 1, 1, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5);
    tab[25] = mk(0, 0,  0,  0,  0, 0, 0, 32'h0,         1, 1, 1, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 5);

    @(negedge clk);
    for (int i = 0; i < 26; i++) cycle(tab[i], 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      rv = mk(0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 0);
      rv.rst  = ($urandom_range(0, 63) == 0);
      rv.iv   = ($urandom_range(0, 3) != 0);
      rv.a    = pool[$urandom_range(0, 5)];
      rv.b    = pool[$urandom_range(0, 5)];
      rv.d    = pool[$urandom_range(0, 5)];
      rv.wbe  = ($urandom_range(0, 2) == 0);
      rv.wbid = pool[$urandom_range(0, 5)];
      rv.wbv  = $urandom;
      rv.ordy = ($urandom_range(0, 3) != 0);
      cycle(rv, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
